// File: rtl/config_loader_pkg.sv
// config_loader_pkg: shared definitions for the configuration loader family.
//   state_e          - loader FSM state encoding
//   DEF_WORD_WIDTH   - default bitstream/readback word width
//   DEF_CHAIN_LEN    - default scan chain length
package config_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_WORD = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  localparam int DEF_WORD_WIDTH = 8;
  localparam int DEF_CHAIN_LEN  = 96;

endpackage

// File: rtl/config_rb_packer.sv
// config_rb_packer: serial-in/parallel-out packer for bits leaving the scan chain tail.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clear           restart packing from an empty word (new load)
//   sample_en       capture sample_bit this edge
//   sample_bit      bit leaving the chain tail
//   last            this sample is the final one of the load (flush partial word)
//   rb_data         packed word, first-captured bit in MSB, partial words left-aligned
//   rb_valid        one-cycle strobe for rb_data
module config_rb_packer
  import config_loader_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int WB_W       = $clog2(WORD_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  sample_en,
  input  logic                  sample_bit,
  input  logic                  last,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid
);

  logic [WORD_WIDTH-1:0] sr_q, sr_d;
  logic [WB_W-1:0]       idx_q, idx_d;
  logic [WORD_WIDTH-1:0] rb_data_q, rb_data_d;
  logic                  rb_valid_q, rb_valid_d;
  logic [WORD_WIDTH-1:0] sr_next;
  logic [WB_W-1:0]       idx_inc;
  logic [WB_W-1:0]       shamt;

  // Packer next-state: accumulate samples, emit on full word or final sample
  always_comb begin
    sr_d       = sr_q;
    idx_d      = idx_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    sr_next    = {sr_q[WORD_WIDTH-2:0], sample_bit};
    idx_inc    = idx_q + WB_W'(1);
    // Zero-fill the low bits of a short final word so it stays left-aligned
    shamt      = WB_W'(WORD_WIDTH) - idx_inc;
    if (clear) begin
      sr_d  = '0;
      idx_d = '0;
    end else if (sample_en) begin
      if ((idx_inc == WB_W'(WORD_WIDTH)) || last) begin
        rb_data_d  = sr_next << shamt;
        rb_valid_d = 1'b1;
        sr_d       = '0;
        idx_d      = '0;
      end else begin
        sr_d  = sr_next;
        idx_d = idx_inc;
      end
    end else begin
      sr_d  = sr_q;
      idx_d = idx_q;
    end
  end

  // Packer state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q       <= '0;
      idx_q      <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      idx_q      <= idx_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;

endmodule

// File: rtl/config_loader.sv
// config_loader: serialises bitstream words onto a configuration scan chain and repacks
// the bits leaving the chain tail into readback words.
// Ports:
//   config_clk, config_rst_n   clock shared with the chain, async active-low reset
//   start                      pulse: begin a full-chain load (only acts when idle)
//   word_data/valid/ready      bitstream word handshake, MSB shifted first
//   cfg_sdo, cfg_en            registered chain head data / shift enable
//   cfg_sdi                    chain tail data
//   rb_data, rb_valid          readback words and strobe
//   busy, done                 load in progress / one-cycle completion pulse
module config_loader
  import config_loader_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1),
  parameter int WB_W       = $clog2(WORD_WIDTH + 1)
) (
  input  logic                  config_clk,
  input  logic                  config_rst_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  cfg_sdo,
  output logic                  cfg_en,
  input  logic                  cfg_sdi,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WB_W-1:0]       wb_q, wb_d;
  logic                  cfg_sdo_q, cfg_sdo_d;
  logic                  cfg_en_q, cfg_en_d;
  logic                  done_q, done_d;
  logic                  word_ready_q, word_ready_d;
  logic                  busy_q, busy_d;
  logic                  pk_clear_s;
  logic                  pk_last_s;

  // FSM next-state, word shifter and bit accounting
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    wb_d      = wb_q;
    cfg_sdo_d = cfg_sdo_q;
    cfg_en_d  = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bit_cnt_d = '0;
          state_d   = ST_WAIT_WORD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_WORD: begin
        if (word_valid && word_ready_q) begin
          shreg_d = word_data;
          wb_d    = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_WAIT_WORD;
        end
      end
      ST_SHIFT: begin
        cfg_sdo_d = shreg_q[WORD_WIDTH-1];
        cfg_en_d  = 1'b1;
        shreg_d   = {shreg_q[WORD_WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        wb_d      = wb_q + WB_W'(1);
        // Chain length wins over word boundary: trailing bits of a short last word are dropped
        if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
          state_d = ST_DONE;
        end else if (wb_q == WB_W'(WORD_WIDTH - 1)) begin
          state_d = ST_WAIT_WORD;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Handshake/status registers follow the next state so they line up with state_q
    word_ready_d = (state_d == ST_WAIT_WORD);
    busy_d       = (state_d != ST_IDLE);
  end

  // FSM and datapath registers
  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      wb_q         <= '0;
      cfg_sdo_q    <= 1'b0;
      cfg_en_q     <= 1'b0;
      done_q       <= 1'b0;
      word_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      wb_q         <= wb_d;
      cfg_sdo_q    <= cfg_sdo_d;
      cfg_en_q     <= cfg_en_d;
      done_q       <= done_d;
      word_ready_q <= word_ready_d;
      busy_q       <= busy_d;
    end
  end

  // The final enabled cycle is the only one spent in ST_DONE
  assign pk_clear_s = (state_q == ST_IDLE) && start;
  assign pk_last_s  = cfg_en_q && (state_q == ST_DONE);

  config_rb_packer #(
    .WORD_WIDTH (WORD_WIDTH),
    .WB_W       (WB_W)
  ) u_packer (
    .clk        (config_clk),
    .rst_n      (config_rst_n),
    .clear      (pk_clear_s),
    .sample_en  (cfg_en_q),
    .sample_bit (cfg_sdi),
    .last       (pk_last_s),
    .rb_data    (rb_data),
    .rb_valid   (rb_valid)
  );

  assign word_ready = word_ready_q;
  assign cfg_sdo    = cfg_sdo_q;
  assign cfg_en     = cfg_en_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
